bpf_wb_stage: RTL and testbench
===============================

Name: bpf_wb_stage

Overview:
- Parametrised writeback stage of the packet-filter CPU pipeline. It is the next generation of the fixed-width stage-2 writeback block.
- It accepts one instruction per handshake from stage 1 and waits for the ALU or packet-memory result when required. It writes the A/X registers and resolves conditional jumps.
- Short forward jumps are absorbed locally by squashing younger instructions. Long jumps raise branch_mispredict with a redirect target.
- It also reports RET completion and raises a memory-wait timeout error.

Parameters:
- DATA_WIDTH, 32: register/result width.
- PC_WIDTH, 10: instruction address width.
- JMP_WIDTH, 8: jt/jf offset width.
- SKIP_DEPTH, 2: largest taken offset handled by squashing instead of flushing; 0 means every nonzero offset flushes.
- MEM_TIMEOUT, 64: maximum cycles spent in WAIT; 0 disables the timeout.

Ports:
- clk, in, 1: clock.
- rst, in, 1: asynchronous reset, active-low.
- restart, in, 1: synchronous pulse that starts a new packet.
- s1_valid, in, 1: stage-1 instruction valid.
- s1_ready, out, 1: stage accepts an instruction.
- s1_pc, in, PC_WIDTH: instruction address.
- s1_wb_sel, in, 2: result source; 00 none, 01 ALU, 10 MEM, 11 IMM.
- s1_dest, in, 1: destination register; 0 = A, 1 = X.
- s1_is_branch, in, 1: conditional jump (result source is the ALU flag).
- s1_is_ret, in, 1: RET instruction (value taken from s1_wb_sel source).
- s1_jt, s1_jf, in, JMP_WIDTH: taken and not-taken offsets.
- s1_imm, in, DATA_WIDTH: immediate value.
- alu_valid, in, 1: ALU result valid.
- alu_result, in, DATA_WIDTH: ALU result.
- alu_flag, in, 1: ALU branch condition.
- mem_valid, in, 1: packet-memory read data valid.
- mem_rdata, in, DATA_WIDTH: packet-memory read data.
- regA_wr_en, out, 1: write enable for A.
- regX_wr_en, out, 1: write enable for X.
- wr_data, out, DATA_WIDTH: register write data.
- branch_mispredict, out, 1: one-cycle redirect pulse.
- branch_target, out, PC_WIDTH: redirect address.
- ret_valid, out, 1: one-cycle RET pulse.
- ret_value, out, DATA_WIDTH: RET value.
- timeout_err, out, 1: sticky memory-timeout flag.

Behaviour:
- Reset (rst=0, asynchronous):
  - All outputs are 0 except s1_ready=1.
  - State is IDLE; skip_cnt=0; timeout counter=0.
  - Reset in the middle of WAIT drops the held instruction with no writeback.
- States: IDLE, WAIT, HALT.
- s1_ready is 1 only in IDLE when branch_mispredict is 0.
- Accept rule: an instruction is accepted on a cycle with s1_valid & s1_ready. The stage latches all s1_* fields.
- Squash (skip_cnt>0 at accept):
  - The instruction is consumed and skip_cnt decrements.
  - No write, branch or RET effect, even if the instruction is a branch or RET.
- Source available at accept (none/IMM, or the selected valid high in the same cycle):
  - Effects are registered and appear at accept+1.
  - The stage stays in IDLE.
- Source not available at accept: go to WAIT.
  - In WAIT, the first cycle with the selected valid high produces effects on the next cycle, then the stage returns to IDLE.
  - Valid on the unselected source is ignored.
- Register write (non-branch, non-RET, wb_sel≠00):
  - One-cycle pulse on regA_wr_en or regX_wr_en, per s1_dest.
  - wr_data holds the source value.
- Branch resolution: off = alu_flag ? jt : jf.
  - off==0: no effect.
  - 1≤off≤SKIP_DEPTH: skip_cnt ← off.
  - off>SKIP_DEPTH: branch_mispredict pulses for one cycle; branch_target = pc+1+off, truncated to PC_WIDTH (wraps); skip_cnt ← 0.
- RET:
  - ret_valid pulses with ret_value = source value.
  - State goes to HALT with s1_ready=0.
- Timeout (MEM_TIMEOUT≠0):
  - If the WAIT count reaches MEM_TIMEOUT with no valid, timeout_err ← 1 and state goes to HALT.
  - The counter resets on entering WAIT.
- restart:
  - From any state: go to IDLE; clear skip_cnt, timeout_err and the held instruction. No outputs are produced.
  - restart takes priority over a simultaneous accept or valid.
- A valid arriving on the same cycle as the timeout expiry completes normally, with no error.

Test Plan:
- IMM 0x1234, dest=X, accepted at cycle 5 → regX_wr_en=1 and wr_data=0x1234 at cycle 6; s1_ready stays 1.
- MEM load to A; mem_valid arrives 3 cycles after accept with 0xDEADBEEF → s1_ready=0 for 3 cycles, then regA_wr_en with 0xDEADBEEF, then s1_ready=1.
- Branch at pc=0x3FF, flag=1, jt=4, SKIP_DEPTH=2 → branch_mispredict pulse with branch_target=0x004 (wrap); s1_ready=0 that cycle.
- Branch with flag=0, jf=2 → next two accepted instructions (one IMM write, one RET) produce no effects; the third writes normally.
- MEM wait with no mem_valid for 64 cycles → timeout_err=1 and s1_ready=0; restart → timeout_err=0 and s1_ready=1.
- RET with IMM 0xFFFF → ret_valid pulse, ret_value=0xFFFF, HALT; rst low during a later WAIT → all outputs clear immediately.

Source files
------------

// File: rtl/bpf_wb_stage.sv
// Writeback stage of the packet-filter pipeline: retires one stage-1 instruction
// per handshake, writes A/X, resolves conditional jumps (short jumps squash
// younger instructions, long jumps redirect), reports RET and memory timeouts.
module bpf_wb_stage #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned PC_WIDTH    = 10,
  parameter int unsigned JMP_WIDTH   = 8,
  parameter int unsigned SKIP_DEPTH  = 2,
  parameter int unsigned MEM_TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  restart,
  input  logic                  s1_valid,
  output logic                  s1_ready,
  input  logic [PC_WIDTH-1:0]   s1_pc,
  input  logic [1:0]            s1_wb_sel,
  input  logic                  s1_dest,
  input  logic                  s1_is_branch,
  input  logic                  s1_is_ret,
  input  logic [JMP_WIDTH-1:0]  s1_jt,
  input  logic [JMP_WIDTH-1:0]  s1_jf,
  input  logic [DATA_WIDTH-1:0] s1_imm,
  input  logic                  alu_valid,
  input  logic [DATA_WIDTH-1:0] alu_result,
  input  logic                  alu_flag,
  input  logic                  mem_valid,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  regA_wr_en,
  output logic                  regX_wr_en,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  branch_mispredict,
  output logic [PC_WIDTH-1:0]   branch_target,
  output logic                  ret_valid,
  output logic [DATA_WIDTH-1:0] ret_value,
  output logic                  timeout_err
);

  typedef enum logic [1:0] {IDLE, WAIT, HALT} state_t;

  typedef struct packed {
    logic [PC_WIDTH-1:0]   pc;
    logic [1:0]            sel;
    logic                  dest;
    logic                  br;
    logic                  ret;
    logic [JMP_WIDTH-1:0]  jt;
    logic [JMP_WIDTH-1:0]  jf;
    logic [DATA_WIDTH-1:0] imm;
  } instr_t;

  localparam int unsigned      TW       = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [TW-1:0]    TO_LIM   = TW'(MEM_TIMEOUT);
  localparam logic [JMP_WIDTH:0] SKIP_LIM = (JMP_WIDTH + 1)'(SKIP_DEPTH);

  state_t                 state, state_n;
  instr_t                 held, held_n, cur, s1_instr;
  logic [JMP_WIDTH-1:0]   skip_cnt, skip_n, off;
  logic [TW-1:0]          tcnt, tcnt_n;
  logic                   accept, src_ok, fire;
  logic [DATA_WIDTH-1:0]  src_val;
  logic                   wa_n, wx_n, mis_n, ret_n, err_n;
  logic [DATA_WIDTH-1:0]  wr_data_n, ret_value_n;
  logic [PC_WIDTH-1:0]    target_n;

  assign s1_ready = (state == IDLE) && !branch_mispredict;
  assign s1_instr = '{pc: s1_pc, sel: s1_wb_sel, dest: s1_dest, br: s1_is_branch,
                      ret: s1_is_ret, jt: s1_jt, jf: s1_jf, imm: s1_imm};

  // State register and registered effect outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state             <= IDLE;
      held              <= '0;
      skip_cnt          <= '0;
      tcnt              <= '0;
      regA_wr_en        <= 1'b0;
      regX_wr_en        <= 1'b0;
      wr_data           <= '0;
      branch_mispredict <= 1'b0;
      branch_target     <= '0;
      ret_valid         <= 1'b0;
      ret_value         <= '0;
      timeout_err       <= 1'b0;
    end else begin
      state             <= state_n;
      held              <= held_n;
      skip_cnt          <= skip_n;
      tcnt              <= tcnt_n;
      regA_wr_en        <= wa_n;
      regX_wr_en        <= wx_n;
      wr_data           <= wr_data_n;
      branch_mispredict <= mis_n;
      branch_target     <= target_n;
      ret_valid         <= ret_n;
      ret_value         <= ret_value_n;
      timeout_err       <= err_n;
    end
  end

  // Next-state, source selection and effect generation
  always_comb begin
    // In WAIT the held copy drives everything; otherwise the live stage-1 fields do,
    // so an instruction whose source is ready at accept retires without a bubble.
    cur    = (state == WAIT) ? held : s1_instr;
    accept = s1_valid && s1_ready;
    off    = alu_flag ? cur.jt : cur.jf;

    src_ok  = 1'b1;
    src_val = '0;
    case (cur.sel)
      2'b01:   begin src_ok = alu_valid; src_val = alu_result; end
      2'b10:   begin src_ok = mem_valid; src_val = mem_rdata;  end
      2'b11:   src_val = cur.imm;
      default: src_val = '0;
    endcase

    state_n     = state;
    held_n      = held;
    skip_n      = skip_cnt;
    tcnt_n      = tcnt;
    err_n       = timeout_err;
    fire        = 1'b0;
    wa_n        = 1'b0;
    wx_n        = 1'b0;
    mis_n       = 1'b0;
    ret_n       = 1'b0;
    wr_data_n   = wr_data;
    target_n    = branch_target;
    ret_value_n = ret_value;

    if (restart) begin
      state_n = IDLE;
      held_n  = '0;
      skip_n  = '0;
      tcnt_n  = '0;
      err_n   = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (skip_cnt != '0) begin
              skip_n = skip_cnt - JMP_WIDTH'(1);
            end else begin
              held_n = s1_instr;
              if (src_ok) begin
                fire = 1'b1;
              end else begin
                state_n = WAIT;
                tcnt_n  = '0;
              end
            end
          end
        end
        WAIT: begin
          // A valid in the expiry cycle wins over the timeout
          if (src_ok) begin
            fire    = 1'b1;
            state_n = IDLE;
          end else if (MEM_TIMEOUT != 0 && (tcnt + TW'(1)) == TO_LIM) begin
            err_n   = 1'b1;
            state_n = HALT;
          end else begin
            tcnt_n = tcnt + TW'(1);
          end
        end
        default: state_n = state;
      endcase

      if (fire) begin
        if (cur.ret) begin
          ret_n       = 1'b1;
          ret_value_n = src_val;
          state_n     = HALT;
        end else if (cur.br) begin
          if (off != '0) begin
            if ({1'b0, off} <= SKIP_LIM) begin
              skip_n = off;
            end else begin
              mis_n    = 1'b1;
              target_n = cur.pc + PC_WIDTH'(1) + PC_WIDTH'(off);
              skip_n   = '0;
            end
          end
        end else if (cur.sel != 2'b00) begin
          wa_n      = !cur.dest;
          wx_n      = cur.dest;
          wr_data_n = src_val;
        end
      end
    end
  end

endmodule

// File: tb/tb_bpf_wb_stage.sv
// Self-checking bench for bpf_wb_stage: table of instructions with expected
// effects fed through a scoreboard, plus hand sequences for timeout, restart,
// RET/HALT and reset during WAIT.
module tb_bpf_wb_stage;

  logic        clk = 1'b0;
  logic        rst, restart, s1_valid, s1_ready;
  logic [9:0]  s1_pc;
  logic [1:0]  s1_wb_sel;
  logic        s1_dest, s1_is_branch, s1_is_ret;
  logic [7:0]  s1_jt, s1_jf;
  logic [31:0] s1_imm;
  logic        alu_valid, alu_flag, mem_valid;
  logic [31:0] alu_result, mem_rdata;
  logic        regA_wr_en, regX_wr_en, branch_mispredict, ret_valid, timeout_err;
  logic [31:0] wr_data, ret_value;
  logic [9:0]  branch_target;

  bpf_wb_stage #(
    .DATA_WIDTH(32), .PC_WIDTH(10), .JMP_WIDTH(8), .SKIP_DEPTH(2), .MEM_TIMEOUT(64)
  ) dut (
    .clk(clk), .rst(rst), .restart(restart),
    .s1_valid(s1_valid), .s1_ready(s1_ready), .s1_pc(s1_pc), .s1_wb_sel(s1_wb_sel),
    .s1_dest(s1_dest), .s1_is_branch(s1_is_branch), .s1_is_ret(s1_is_ret),
    .s1_jt(s1_jt), .s1_jf(s1_jf), .s1_imm(s1_imm),
    .alu_valid(alu_valid), .alu_result(alu_result), .alu_flag(alu_flag),
    .mem_valid(mem_valid), .mem_rdata(mem_rdata),
    .regA_wr_en(regA_wr_en), .regX_wr_en(regX_wr_en), .wr_data(wr_data),
    .branch_mispredict(branch_mispredict), .branch_target(branch_target),
    .ret_valid(ret_valid), .ret_value(ret_value), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Effect kinds: bit0 write A, bit1 write X, bit2 mispredict, bit3 RET
  localparam logic [3:0] KN = 4'b0000, KA = 4'b0001, KX = 4'b0010,
                         KM = 4'b0100, KR = 4'b1000;

  typedef struct {
    logic [9:0]  pc;
    logic [1:0]  sel;
    logic        dest, br, ret;
    logic [7:0]  jt, jf;
    logic [31:0] imm, val;
    logic        flag;
    int          lat;
    logic [3:0]  ek;
    logic [31:0] ev;
  } vec_t;

  typedef struct {
    logic [3:0]  k;
    logic [31:0] v;
  } exp_t;

  exp_t sb[$];
  int   passed = 0;
  int   total  = 0;
  vec_t tbl[18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic vec_t mk(input logic [9:0] pc, input logic [1:0] sel, input logic dest,
                              input logic br, input logic ret, input logic [7:0] jt,
                              input logic [7:0] jf, input logic [31:0] val, input logic flag,
                              input int lat, input logic [3:0] ek, input logic [31:0] ev);
    vec_t v;
    v.pc = pc; v.sel = sel; v.dest = dest; v.br = br; v.ret = ret;
    v.jt = jt; v.jf = jf; v.val = val; v.flag = flag; v.lat = lat; v.ek = ek; v.ev = ev;
    v.imm = (sel == 2'b11) ? val : ~val;
    return v;
  endfunction

  // Scoreboard: every effect pulse must match the oldest expected effect
  always @(negedge clk) begin : monitor
    logic [3:0]  ak;
    logic [31:0] av;
    exp_t        e;
    ak = {ret_valid, branch_mispredict, regX_wr_en, regA_wr_en};
    if (ak != 4'b0000) begin
      av = ret_valid ? ret_value : (branch_mispredict ? 32'(branch_target) : wr_data);
      if (sb.size() == 0) begin
        total++;
        $display("FAIL unexpected_effect: got kind %b value 0x%0h, required no effect", ak, av);
      end else begin
        e = sb.pop_front();
        check("effect_kind", 32'(ak), 32'(e.k));
        check("effect_value", av, e.v);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    s1_valid = 1'b0; alu_valid = 1'b0; mem_valid = 1'b0;
    alu_result = '0; mem_rdata = '0; alu_flag = 1'b0;
  endtask

  task automatic drive_src(input logic [1:0] sel, input logic [31:0] val, input logic flag);
    if (sel == 2'b01) begin alu_valid = 1'b1; alu_result = val; alu_flag = flag; end
    else if (sel == 2'b10) begin mem_valid = 1'b1; mem_rdata = val; end
  endtask

  // Valid on the source the instruction is not waiting for
  task automatic noise(input logic [1:0] sel);
    if (sel == 2'b01) begin mem_valid = 1'b1; mem_rdata = 32'hBAD0BAD0; end
    else if (sel == 2'b10) begin alu_valid = 1'b1; alu_result = 32'hBAD1BAD1; alu_flag = 1'b1; end
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 20 && !s1_ready; i++) tick();
    if (!s1_ready) begin
      total++;
      $display("FAIL wait_ready: got s1_ready=0 after 20 cycles, required 1");
    end
  endtask

  task automatic expect_effect(input logic [3:0] k, input logic [31:0] v);
    exp_t e;
    e.k = k; e.v = v;
    sb.push_back(e);
  endtask

  task automatic issue(input vec_t v, input string name);
    wait_ready();
    s1_valid = 1'b1; s1_pc = v.pc; s1_wb_sel = v.sel; s1_dest = v.dest;
    s1_is_branch = v.br; s1_is_ret = v.ret; s1_jt = v.jt; s1_jf = v.jf; s1_imm = v.imm;
    if (v.ek != KN) expect_effect(v.ek, v.ev);
    if (v.lat == 0) drive_src(v.sel, v.val, v.flag);
    tick();
    clear_in();
    for (int i = 1; i <= v.lat; i++) begin
      check({name, "_ready_wait"}, 32'(s1_ready), 0);
      if (i < v.lat) noise(v.sel);
      else drive_src(v.sel, v.val, v.flag);
      tick();
      clear_in();
    end
    check({name, "_ready_after"}, 32'(s1_ready), (v.ek[2] || v.ek[3]) ? 0 : 1);
  endtask

  task automatic accept_mem(input logic dest, input logic [9:0] pc);
    wait_ready();
    s1_valid = 1'b1; s1_pc = pc; s1_wb_sel = 2'b10; s1_dest = dest;
    s1_is_branch = 1'b0; s1_is_ret = 1'b0; s1_jt = '0; s1_jf = '0; s1_imm = 32'h0F0F0F0F;
    tick();
    clear_in();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    tbl[0]  = mk(10'h005, 2'b11, 1, 0, 0, 0,  0, 32'h1234,     0, 0, KX, 32'h1234);
    tbl[1]  = mk(10'h006, 2'b10, 0, 0, 0, 0,  0, 32'hDEADBEEF, 0, 3, KA, 32'hDEADBEEF);
    tbl[2]  = mk(10'h007, 2'b01, 1, 0, 0, 0,  0, 32'h000000AA, 0, 0, KX, 32'h000000AA);
    tbl[3]  = mk(10'h008, 2'b01, 0, 0, 0, 0,  0, 32'h00000055, 0, 2, KA, 32'h00000055);
    tbl[4]  = mk(10'h3FF, 2'b01, 0, 1, 0, 4,  9, 32'h0,        1, 0, KM, 32'h004);
    tbl[5]  = mk(10'h010, 2'b01, 0, 1, 0, 7,  2, 32'h0,        0, 0, KN, 32'h0);
    tbl[6]  = mk(10'h011, 2'b11, 0, 0, 0, 0,  0, 32'h77,       0, 0, KN, 32'h0);
    tbl[7]  = mk(10'h012, 2'b11, 0, 0, 1, 0,  0, 32'h99,       0, 0, KN, 32'h0);
    tbl[8]  = mk(10'h013, 2'b11, 0, 0, 0, 0,  0, 32'hABCD,     0, 0, KA, 32'hABCD);
    tbl[9]  = mk(10'h020, 2'b01, 0, 1, 0, 0,  5, 32'h0,        1, 0, KN, 32'h0);
    tbl[10] = mk(10'h021, 2'b11, 1, 0, 0, 0,  0, 32'h1,        0, 0, KX, 32'h1);
    tbl[11] = mk(10'h030, 2'b01, 0, 1, 0, 1,  3, 32'h0,        0, 2, KM, 32'h034);
    tbl[12] = mk(10'h040, 2'b01, 0, 1, 0, 2,  0, 32'h0,        1, 0, KN, 32'h0);
    tbl[13] = mk(10'h041, 2'b01, 0, 1, 0, 50, 0, 32'h0,        1, 0, KN, 32'h0);
    tbl[14] = mk(10'h042, 2'b01, 1, 0, 0, 0,  0, 32'h5,        0, 0, KN, 32'h0);
    tbl[15] = mk(10'h043, 2'b00, 0, 0, 0, 0,  0, 32'h0,        0, 0, KN, 32'h0);
    tbl[16] = mk(10'h044, 2'b01, 0, 1, 0, 0,  3, 32'h0,        0, 0, KM, 32'h048);
    tbl[17] = mk(10'h050, 2'b10, 0, 0, 0, 0,  0, 32'h12345678, 0, 0, KA, 32'h12345678);

    rst = 1'b0; restart = 1'b0;
    s1_pc = '0; s1_wb_sel = '0; s1_dest = 1'b0; s1_is_branch = 1'b0; s1_is_ret = 1'b0;
    s1_jt = '0; s1_jf = '0; s1_imm = '0;
    clear_in();
    #2;
    check("reset_ready", 32'(s1_ready), 1);
    check("reset_wr_en", 32'({regA_wr_en, regX_wr_en}), 0);
    check("reset_pulses", 32'({branch_mispredict, ret_valid, timeout_err}), 0);
    check("reset_wr_data", wr_data, 0);
    #1 rst = 1'b1;
    tick();

    for (int i = 0; i < 18; i++) issue(tbl[i], $sformatf("row%0d", i));

    // Valid in the same cycle the timeout would expire: normal completion
    accept_mem(1'b0, 10'h060);
    for (int i = 0; i < 63; i++) tick();
    check("expiry_pre_err", 32'(timeout_err), 0);
    check("expiry_pre_ready", 32'(s1_ready), 0);
    expect_effect(KA, 32'h0000CAFE);
    mem_valid = 1'b1; mem_rdata = 32'h0000CAFE;
    tick();
    clear_in();
    check("expiry_err", 32'(timeout_err), 0);
    check("expiry_ready", 32'(s1_ready), 1);

    // Restart beats a simultaneous valid in WAIT; restart also clears skip_cnt
    accept_mem(1'b1, 10'h070);
    tick();
    restart = 1'b1; mem_valid = 1'b1; mem_rdata = 32'h00000111;
    tick();
    restart = 1'b0; clear_in();
    check("restart_wait_ready", 32'(s1_ready), 1);
    issue(mk(10'h080, 2'b01, 0, 1, 0, 0, 1, 32'h0, 0, 0, KN, 32'h0), "skip1");
    restart = 1'b1;
    tick();
    restart = 1'b0;
    issue(mk(10'h081, 2'b11, 1, 0, 0, 0, 0, 32'h42, 0, 0, KX, 32'h42), "post_restart");

    // Memory timeout, sticky error, restart recovery
    accept_mem(1'b0, 10'h090);
    for (int i = 0; i < 63; i++) tick();
    check("to_before_err", 32'(timeout_err), 0);
    tick();
    check("to_err", 32'(timeout_err), 1);
    check("to_ready", 32'(s1_ready), 0);
    mem_valid = 1'b1; mem_rdata = 32'h00000222;
    tick(); tick();
    clear_in();
    check("to_sticky", 32'(timeout_err), 1);
    restart = 1'b1;
    tick();
    restart = 1'b0;
    check("to_restart_err", 32'(timeout_err), 0);
    check("to_restart_ready", 32'(s1_ready), 1);

    // RET with immediate value, then HALT ignores further instructions
    issue(mk(10'h0A0, 2'b11, 0, 0, 1, 0, 0, 32'h0000FFFF, 0, 0, KR, 32'h0000FFFF), "ret");
    s1_valid = 1'b1; s1_wb_sel = 2'b11; s1_is_ret = 1'b0; s1_imm = 32'h333;
    tick(); tick(); tick();
    clear_in();
    check("halt_ready", 32'(s1_ready), 0);
    restart = 1'b1;
    tick();
    restart = 1'b0;
    check("halt_restart_ready", 32'(s1_ready), 1);

    // Asynchronous reset during WAIT clears everything and drops the instruction
    accept_mem(1'b0, 10'h0B0);
    tick();
    #2 rst = 1'b0;
    #1;
    check("arst_ready", 32'(s1_ready), 1);
    check("arst_wr_data", wr_data, 0);
    check("arst_ret_value", ret_value, 0);
    check("arst_target", 32'(branch_target), 0);
    check("arst_flags", 32'({regA_wr_en, regX_wr_en, branch_mispredict, ret_valid, timeout_err}), 0);
    rst = 1'b1;
    mem_valid = 1'b1; mem_rdata = 32'h0000EEEE;
    tick();
    clear_in();
    tick();
    check("arst_after_ready", 32'(s1_ready), 1);

    check("scoreboard_empty", 32'(sb.size()), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
